// File: rtl/seq_ntt_engine.sv
// Sequential N-point naive NTT: streams in N coefficients, computes X[i] = sum x[j]*omega^(i*j) mod m
// with one modular MAC per cycle, streams out N results. Optional inverse scaling under NTT_INVERSE_EN.
module seq_ntt_engine #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic [W-1:0] omega,
    input  logic [W-1:0] mod,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         busy
`ifdef NTT_INVERSE_EN
    ,
    input  logic         inv,
    input  logic [W-1:0] ninv
`endif
);

    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned SW = 2 * W + 1;
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

    // Full modulo; a zero modulus yields zero instead of an undefined divide.
    function automatic logic [W-1:0] reduce(input logic [SW-1:0] v, input logic [W-1:0] m);
        logic [SW-1:0] r;
        r = '0;
        if (m != '0) r = v % SW'(m);
        return W'(r);
    endfunction

    state_t        state;
    logic [LW-1:0] in_cnt, row, col, k;
    logic [W-1:0]  acc_q, f_q, w_q, omega_q, mod_q;
    logic          scale_q;
    logic          inv_act;
    logic [W-1:0]  xbuf [N];
    logic [W-1:0]  ybuf [N];

    logic [W-1:0]  x_cur_c, f_cur_c, acc_cur_c, mac_c, fnext_c, wnext_c, y_wd_c;
    logic          x_we_c, y_we_c;

`ifdef NTT_INVERSE_EN
    logic          inv_q;
    logic [W-1:0]  ninv_q;
    assign inv_act = inv_q;
`else
    assign inv_act = 1'b0;
`endif

    // MAC datapath and buffer write controls
    always_comb begin
        x_cur_c   = xbuf[col];
        f_cur_c   = (col == '0) ? reduce(SW'(1), mod_q) : f_q;
        acc_cur_c = (col == '0) ? '0 : acc_q;
        mac_c     = reduce(SW'(acc_cur_c) + SW'(PW'(x_cur_c) * PW'(f_cur_c)), mod_q);
        fnext_c   = reduce(SW'(PW'(f_cur_c) * PW'(w_q)), mod_q);
        wnext_c   = reduce(SW'(PW'(w_q) * PW'(omega_q)), mod_q);
        y_wd_c    = mac_c;
`ifdef NTT_INVERSE_EN
        if (scale_q) y_wd_c = reduce(SW'(PW'(acc_q) * PW'(ninv_q)), mod_q);
`endif
        x_we_c = s_valid && s_ready && ((state == IDLE) || (state == LOAD));
        y_we_c = (state == COMPUTE) && (scale_q || ((col == LAST) && !inv_act));
    end

    always_ff @(posedge clk) begin
        if (x_we_c) xbuf[in_cnt] <= s_data;
        if (y_we_c) ybuf[row] <= y_wd_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            in_cnt  <= '0;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            acc_q   <= '0;
            f_q     <= '0;
            w_q     <= '0;
            omega_q <= '0;
            mod_q   <= '0;
            scale_q <= 1'b0;
`ifdef NTT_INVERSE_EN
            inv_q   <= 1'b0;
            ninv_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        omega_q <= omega;
                        mod_q   <= mod;
`ifdef NTT_INVERSE_EN
                        inv_q   <= inv;
                        ninv_q  <= ninv;
`endif
                        in_cnt  <= LW'(1);
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        if (in_cnt == LAST) begin
                            state   <= COMPUTE;
                            s_ready <= 1'b0;
                            in_cnt  <= '0;
                            row     <= '0;
                            col     <= '0;
                            scale_q <= 1'b0;
                            w_q     <= reduce(SW'(1), mod_q);
                        end else begin
                            in_cnt <= in_cnt + LW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (scale_q || ((col == LAST) && !inv_act)) begin
                        // Row complete: X[row] is being written this cycle
                        scale_q <= 1'b0;
                        col     <= '0;
                        row     <= row + LW'(1);
                        if (!scale_q) w_q <= wnext_c;
                        if (row == LAST) begin
                            state   <= OUTPUT;
                            row     <= '0;
                            k       <= '0;
                            m_valid <= 1'b1;
                            m_data  <= ybuf[0];
                            m_last  <= 1'b0;
                        end
                    end else if (col == LAST) begin
                        acc_q   <= mac_c;
                        w_q     <= wnext_c;
                        scale_q <= 1'b1;
                    end else begin
                        acc_q <= mac_c;
                        f_q   <= fnext_c;
                        col   <= col + LW'(1);
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        if (k == LAST) begin
                            state   <= IDLE;
                            k       <= '0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end else begin
                            k      <= k + LW'(1);
                            m_data <= ybuf[k + LW'(1)];
                            m_last <= ((k + LW'(1)) == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_ntt_engine.sv
// Directed self-checking bench for seq_ntt_engine (N=8, W=8); inverse test compiled with NTT_INVERSE_EN.
module tb_seq_ntt_engine;
    localparam int unsigned N = 8;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic [W-1:0] omega = '0;
    logic [W-1:0] mod = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;
`ifdef NTT_INVERSE_EN
    logic         inv = 1'b0;
    logic [W-1:0] ninv = '0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] xv [N];
    logic [W-1:0] got [N];
    logic         got_last [N];
    int acc_cyc, first_cyc, stall_changes, sr_seen, beats;

    seq_ntt_engine #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .omega(omega), .mod(mod),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
`ifdef NTT_INVERSE_EN
        , .inv(inv), .ninv(ninv)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Feed xv; omega/mod are scrambled after the first beat to show they are latched once.
    task automatic send(input logic [W-1:0] om, input logic [W-1:0] md, input bit hold);
        int n;
        omega = om;
        mod   = md;
        for (int j = 0; j < N; j++) begin
            s_valid = 1'b1;
            s_data  = xv[j];
            n = 0;
            while (!s_ready && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 1000) begin
                checks++; errors++;
                $display("FAIL send_timeout beat %0d s_ready=%b required 1", j, s_ready);
            end
            @(posedge clk); #1;
            if (j == 0) begin
                omega = ~om;
                mod   = ~md;
            end
        end
        acc_cyc = cyc;
        if (hold) s_data = 8'h55;
        else s_valid = 1'b0;
    endtask

    // Collect N results; optional 1-0-0-1 m_ready pattern once m_valid is up.
    task automatic recv(input bit bp_en);
        int n, p;
        bit stalled;
        logic [W-1:0] held;
        beats = 0; first_cyc = -1; stall_changes = 0; sr_seen = 0;
        n = 0; p = 0; stalled = 0; held = '0;
        while (beats < N && n < 3000) begin
            if (m_valid && first_cyc < 0) first_cyc = cyc;
            m_ready = bp_en ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            if (m_valid) p++;
            if (s_ready) sr_seen++;
            if (stalled && m_data !== held) stall_changes++;
            if (m_valid && m_ready) begin
                got[beats] = m_data;
                got_last[beats] = m_last;
                beats++;
                stalled = 0;
            end else if (m_valid) begin
                stalled = 1;
                held = m_data;
            end
            @(posedge clk); #1;
            n++;
        end
        m_ready = 1'b1;
        if (beats < N) begin
            checks++; errors++;
            $display("FAIL recv_timeout beats %0d required %0d", beats, N);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, m_valid, m_last, busy} !== 4'b0000 || m_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_values got s_ready=%b m_valid=%b m_last=%b busy=%b m_data=%0d required all 0",
                     s_ready, m_valid, m_last, busy, m_data);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_s_ready got %b required 1", s_ready);
        end
    endtask

    task automatic test_impulse(input string tag);
        for (int i = 0; i < N; i++) xv[i] = '0;
        xv[0] = 8'd1;
        send(8'd2, 8'd17, 1'b0);
        recv(1'b0);
        checks++;
        if (first_cyc - acc_cyc !== 64) begin
            errors++;
            $display("FAIL %s_latency got %0d required 64", tag, first_cyc - acc_cyc);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== 8'd1 || got_last[i] !== (i == N - 1)) begin
                errors++;
                $display("FAIL %s X[%0d] got %0d last=%b required 1 last=%b", tag, i, got[i], got_last[i], i == N - 1);
            end
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] ex [N];
        ex = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
        for (int i = 0; i < N; i++) xv[i] = '0;
        xv[1] = 8'd1;
        send(8'd2, 8'd17, 1'b0);
        recv(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== ex[i]) begin
                errors++;
                $display("FAIL shift X[%0d] got %0d required %0d", i, got[i], ex[i]);
            end
        end
        for (int i = 0; i < N; i++) xv[i] = 8'd1;
        send(8'd2, 8'd17, 1'b0);
        recv(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== ((i == 0) ? 8'd8 : 8'd0)) begin
                errors++;
                $display("FAIL ones X[%0d] got %0d required %0d", i, got[i], (i == 0) ? 8 : 0);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ex [N];
        ex = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd15, 8'd13, 8'd9};
        for (int i = 0; i < N; i++) xv[i] = '0;
        xv[1] = 8'd1;
        send(8'd2, 8'd17, 1'b1);
        recv(1'b1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== ex[i]) begin
                errors++;
                $display("FAIL bp X[%0d] got %0d required %0d", i, got[i], ex[i]);
            end
        end
        checks++;
        if (stall_changes !== 0) begin
            errors++;
            $display("FAIL bp_stall_stable changes %0d required 0", stall_changes);
        end
        checks++;
        if (sr_seen !== 0) begin
            errors++;
            $display("FAIL bp_no_accept s_ready high %0d cycles required 0", sr_seen);
        end
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_return_idle s_ready=%b busy=%b required 1 0", s_ready, busy);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_degenerate();
        xv = '{8'd3, 8'd250, 8'd7, 8'd1, 8'd0, 8'd99, 8'd255, 8'd16};
        send(8'd5, 8'd1, 1'b0);
        recv(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== 8'd0) begin
                errors++;
                $display("FAIL mod1 X[%0d] got %0d required 0", i, got[i]);
            end
        end
        send(8'd2, 8'd0, 1'b0);
        recv(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== 8'd0) begin
                errors++;
                $display("FAIL mod0 X[%0d] got %0h required 0", i, got[i]);
            end
        end
        for (int i = 0; i < N; i++) xv[i] = 8'd250;
        send(8'd1, 8'd251, 1'b0);
        recv(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== 8'd243) begin
                errors++;
                $display("FAIL mod251 X[%0d] got %0d required 243", i, got[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int mv_seen;
        for (int i = 0; i < N; i++) xv[i] = 8'd9;
        send(8'd2, 8'd17, 1'b0);
        repeat (27) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_last, busy} !== 4'b0000 || m_data !== 8'd0) begin
            errors++;
            $display("FAIL midreset_values got s_ready=%b m_valid=%b m_last=%b busy=%b m_data=%0d required all 0",
                     s_ready, m_valid, m_last, busy, m_data);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        mv_seen = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (m_valid || busy) mv_seen++;
        end
        checks++;
        if (mv_seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_output m_valid/busy high %0d cycles required 0", mv_seen);
        end
        test_impulse("post_reset");
    endtask

`ifdef NTT_INVERSE_EN
    task automatic test_inverse();
        for (int i = 0; i < N; i++) xv[i] = '0;
        xv[0] = 8'd8;
        inv = 1'b1; ninv = 8'd15;
        send(8'd9, 8'd17, 1'b0);
        recv(1'b0);
        checks++;
        if (first_cyc - acc_cyc !== 72) begin
            errors++;
            $display("FAIL inv_latency got %0d required 72", first_cyc - acc_cyc);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== 8'd1) begin
                errors++;
                $display("FAIL inv_impulse X[%0d] got %0d required 1", i, got[i]);
            end
        end
        inv = 1'b0;
        for (int i = 0; i < N; i++) xv[i] = '0;
        xv[1] = 8'd1;
        send(8'd2, 8'd17, 1'b0);
        recv(1'b0);
        for (int i = 0; i < N; i++) xv[i] = got[i];
        inv = 1'b1;
        send(8'd9, 8'd17, 1'b0);
        recv(1'b0);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== ((i == 1) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL roundtrip x[%0d] got %0d required %0d", i, got[i], (i == 1) ? 1 : 0);
            end
        end
        inv = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_impulse("impulse");
        test_patterns();
        test_backpressure();
        test_degenerate();
        test_reset_mid();
`ifdef NTT_INVERSE_EN
        test_inverse();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
